// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the fetch path and the load/store data path.
// Latency: store done 2 cycles after the request is sampled, read done 2 + MEM_LATENCY cycles after.
// Backpressure: requesters hold req until their done pulse; requests are sampled only while idle.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-low reset
//   i_req/i_addr      fetch request (held until i_done); i_done/i_rdata completion and data
//   d_req/d_we/...    load/store request (held until d_done); d_done/d_rdata completion and data
//   mem_*             memory macro strobe, write enable, address, write data, read data
//   busy, owner       arbiter not idle; current/last grant (0 = fetch, 1 = data)
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 64,
  parameter int MEM_LATENCY = 1,   // 1..4
  parameter int MAX_STREAK  = 4    // 1..15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_done,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  typedef enum logic [2:0] {IDLE, ACCESS, WAIT, CAPTURE, DONE} state_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);
  // WAIT runs MEM_LATENCY-1 cycles; the counter is loaded with one less so it exits on zero.
  localparam logic [1:0] WAIT_INIT  = (MEM_LATENCY > 1) ? 2'(MEM_LATENCY - 2) : 2'd0;

  state_t            state, state_nx;
  logic [3:0]        streak, streak_nx;
  logic [1:0]        wait_cnt, wait_cnt_nx;
  logic              grant_d;
  logic              mem_en_nx, mem_we_nx, owner_nx, busy_nx, i_done_nx, d_done_nx;
  logic [ADDR_W-1:0] mem_addr_nx;
  logic [DATA_W-1:0] mem_wdata_nx, i_rdata_nx, d_rdata_nx;

  always_comb begin
    state_nx     = state;
    streak_nx    = streak;
    wait_cnt_nx  = wait_cnt;
    grant_d      = 1'b0;
    mem_en_nx    = 1'b0;
    mem_we_nx    = mem_we;
    mem_addr_nx  = mem_addr;
    mem_wdata_nx = mem_wdata;
    owner_nx     = owner;
    i_done_nx    = 1'b0;
    d_done_nx    = 1'b0;
    i_rdata_nx   = i_rdata;
    d_rdata_nx   = d_rdata;

    case (state)
      IDLE: begin
        if (i_req || d_req) begin
          // Data wins ties unless it has already starved a waiting fetch MAX_STREAK times.
          grant_d      = d_req && !(i_req && (streak == STREAK_MAX));
          state_nx     = ACCESS;
          mem_en_nx    = 1'b1;
          owner_nx     = grant_d;
          mem_addr_nx  = grant_d ? d_addr : i_addr;
          mem_we_nx    = grant_d && d_we;
          mem_wdata_nx = grant_d ? d_wdata : '0;
          // The streak only measures data grants that actually bypassed a waiting fetch.
          if (!grant_d || !i_req) begin
            streak_nx = '0;
          end else if (streak != STREAK_MAX) begin
            streak_nx = streak + 4'd1;
          end
        end
      end
      ACCESS: begin
        if (mem_we) begin
          // Only the data port can store, so completion goes to d_done.
          state_nx  = DONE;
          d_done_nx = 1'b1;
        end else if (MEM_LATENCY == 1) begin
          state_nx = CAPTURE;
        end else begin
          state_nx    = WAIT;
          wait_cnt_nx = WAIT_INIT;
        end
      end
      WAIT: begin
        if (wait_cnt == 2'd0) begin
          state_nx = CAPTURE;
        end else begin
          wait_cnt_nx = wait_cnt - 2'd1;
        end
      end
      CAPTURE: begin
        state_nx = DONE;
        if (owner) begin
          d_rdata_nx = mem_rdata;
          d_done_nx  = 1'b1;
        end else begin
          i_rdata_nx = mem_rdata;
          i_done_nx  = 1'b1;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    busy_nx = (state_nx != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      streak    <= '0;
      wait_cnt  <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      owner     <= 1'b0;
      busy      <= 1'b0;
      i_done    <= 1'b0;
      d_done    <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      state     <= state_nx;
      streak    <= streak_nx;
      wait_cnt  <= wait_cnt_nx;
      mem_en    <= mem_en_nx;
      mem_we    <= mem_we_nx;
      mem_addr  <= mem_addr_nx;
      mem_wdata <= mem_wdata_nx;
      owner     <= owner_nx;
      busy      <= busy_nx;
      i_done    <= i_done_nx;
      d_done    <= d_done_nx;
      i_rdata   <= i_rdata_nx;
      d_rdata   <= d_rdata_nx;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: MEM_LATENCY=1, MAX_STREAK=4. Instance 1: MEM_LATENCY=3, MAX_STREAK=2.
  logic        i_req [2];
  logic [31:0] i_addr [2];
  logic        i_done [2];
  logic [63:0] i_rdata [2];
  logic        d_req [2];
  logic        d_we [2];
  logic [31:0] d_addr [2];
  logic [63:0] d_wdata [2];
  logic        d_done [2];
  logic [63:0] d_rdata [2];
  logic        mem_en [2];
  logic        mem_we [2];
  logic [31:0] mem_addr [2];
  logic [63:0] mem_wdata [2];
  logic [63:0] mem_rdata [2];
  logic        busy [2];
  logic        owner [2];

  int checks = 0;
  int errors = 0;

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic int max_of(input int k);
    return (k == 0) ? 4 : 2;
  endfunction

  // Memory contents as a pure function of the address.
  function automatic logic [63:0] mfun(input logic [31:0] a);
    if (a == 32'h100) return 64'hDEADBEEF_CAFEF00D;
    return {a ^ 32'h5A5A_0000, ~a};
  endfunction

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(64), .MEM_LATENCY(1), .MAX_STREAK(4)) u_dut0 (
    .clk(clk), .reset(reset),
    .i_req(i_req[0]), .i_addr(i_addr[0]), .i_done(i_done[0]), .i_rdata(i_rdata[0]),
    .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
    .d_done(d_done[0]), .d_rdata(d_rdata[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]),
    .busy(busy[0]), .owner(owner[0])
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(64), .MEM_LATENCY(3), .MAX_STREAK(2)) u_dut1 (
    .clk(clk), .reset(reset),
    .i_req(i_req[1]), .i_addr(i_addr[1]), .i_done(i_done[1]), .i_rdata(i_rdata[1]),
    .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
    .d_done(d_done[1]), .d_rdata(d_rdata[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]),
    .busy(busy[1]), .owner(owner[1])
  );

  // Memory macro: read data appears MEM_LATENCY cycles after the strobe; junk otherwise.
  logic [63:0] pipe [2][4];
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      pipe[k][0] <= (mem_en[k] && !mem_we[k]) ? mfun(mem_addr[k]) : {$urandom, $urandom};
      for (int j = 1; j < 4; j++) pipe[k][j] <= pipe[k][j-1];
    end
  end
  assign mem_rdata[0] = pipe[0][0];
  assign mem_rdata[1] = pipe[1][2];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #3;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({mem_en[k], mem_we[k], i_done[k], d_done[k], busy[k], owner[k]} !== 6'b0) begin
        errors++;
        $display("FAIL reset_ctl[%0d]: got %b want 000000", k,
                 {mem_en[k], mem_we[k], i_done[k], d_done[k], busy[k], owner[k]});
      end
      checks++;
      if (mem_addr[k] !== 32'h0 || mem_wdata[k] !== 64'h0 || i_rdata[k] !== 64'h0 || d_rdata[k] !== 64'h0) begin
        errors++;
        $display("FAIL reset_bus[%0d]: addr=%h wdata=%h irdata=%h drdata=%h want all 0", k,
                 mem_addr[k], mem_wdata[k], i_rdata[k], d_rdata[k]);
      end
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_load();
    d_we[0] = 1'b0; d_addr[0] = 32'h100; d_req[0] = 1'b1;         // cycle 0
    checks++;
    if (mem_en[0] !== 1'b0) begin errors++; $display("FAIL load_c0_en: got %b want 0", mem_en[0]); end
    tick();                                                        // cycle 1
    checks++;
    if ({mem_en[0], mem_we[0], busy[0], owner[0]} !== 4'b1011 || mem_addr[0] !== 32'h100) begin
      errors++;
      $display("FAIL load_c1: en/we/busy/owner=%b addr=%h want 1011 100",
               {mem_en[0], mem_we[0], busy[0], owner[0]}, mem_addr[0]);
    end
    tick();                                                        // cycle 2
    checks++;
    if (mem_en[0] !== 1'b0 || d_done[0] !== 1'b0) begin
      errors++; $display("FAIL load_c2: en=%b d_done=%b want 0 0", mem_en[0], d_done[0]);
    end
    tick();                                                        // cycle 3
    checks++;
    if (d_done[0] !== 1'b1 || i_done[0] !== 1'b0) begin
      errors++; $display("FAIL load_c3_done: d_done=%b i_done=%b want 1 0", d_done[0], i_done[0]);
    end
    checks++;
    if (d_rdata[0] !== 64'hDEADBEEF_CAFEF00D) begin
      errors++; $display("FAIL load_rdata: got %h want deadbeefcafef00d", d_rdata[0]);
    end
    d_req[0] = 1'b0;
    tick();                                                        // cycle 4
    checks++;
    if (d_done[0] !== 1'b0 || busy[0] !== 1'b0 || mem_en[0] !== 1'b0) begin
      errors++; $display("FAIL load_c4_idle: d_done=%b busy=%b en=%b want 0 0 0", d_done[0], busy[0], mem_en[0]);
    end
  endtask

  task automatic test_store();
    d_we[0] = 1'b1; d_addr[0] = 32'h40; d_wdata[0] = 64'h1234; d_req[0] = 1'b1;
    tick();                                                        // cycle 1
    checks++;
    if (mem_en[0] !== 1'b1 || mem_we[0] !== 1'b1 || mem_addr[0] !== 32'h40 || mem_wdata[0] !== 64'h1234) begin
      errors++;
      $display("FAIL store_c1: en=%b we=%b addr=%h wdata=%h want 1 1 40 1234",
               mem_en[0], mem_we[0], mem_addr[0], mem_wdata[0]);
    end
    tick();                                                        // cycle 2
    checks++;
    if (d_done[0] !== 1'b1 || i_done[0] !== 1'b0) begin
      errors++; $display("FAIL store_c2_done: d_done=%b i_done=%b want 1 0", d_done[0], i_done[0]);
    end
    d_req[0] = 1'b0; d_we[0] = 1'b0;
    tick();
    checks++;
    if (d_done[0] !== 1'b0 || busy[0] !== 1'b0 || d_rdata[0] !== 64'hDEADBEEF_CAFEF00D) begin
      errors++; $display("FAIL store_after: d_done=%b busy=%b d_rdata=%h want 0 0 deadbeefcafef00d",
                         d_done[0], busy[0], d_rdata[0]);
    end
  endtask

  task automatic test_fetch_lat3();
    i_addr[1] = 32'h0; i_req[1] = 1'b1;                            // cycle 0
    tick();                                                        // cycle 1
    checks++;
    if (mem_en[1] !== 1'b1 || mem_we[1] !== 1'b0 || owner[1] !== 1'b0 || mem_addr[1] !== 32'h0) begin
      errors++; $display("FAIL fetch3_c1: en=%b we=%b owner=%b addr=%h want 1 0 0 0",
                         mem_en[1], mem_we[1], owner[1], mem_addr[1]);
    end
    for (int c = 2; c <= 4; c++) begin
      tick();
      checks++;
      if (mem_en[1] !== 1'b0 || busy[1] !== 1'b1 || i_done[1] !== 1'b0) begin
        errors++; $display("FAIL fetch3_c%0d: en=%b busy=%b i_done=%b want 0 1 0", c, mem_en[1], busy[1], i_done[1]);
      end
    end
    tick();                                                        // cycle 5
    checks++;
    if (i_done[1] !== 1'b1 || d_done[1] !== 1'b0 || i_rdata[1] !== mfun(32'h0)) begin
      errors++; $display("FAIL fetch3_c5: i_done=%b d_done=%b i_rdata=%h want 1 0 %h",
                         i_done[1], d_done[1], i_rdata[1], mfun(32'h0));
    end
    i_req[1] = 1'b0;
    tick();
    checks++;
    if (i_done[1] !== 1'b0 || busy[1] !== 1'b0) begin
      errors++; $display("FAIL fetch3_after: i_done=%b busy=%b want 0 0", i_done[1], busy[1]);
    end
  endtask

  // Both requesters held; order follows the streak rule, each grant is a read.
  task automatic test_streak(input int k, input int n);
    int streak_m = 0;
    int got = 0;
    int cyc = 0;
    int lat = lat_of(k);
    i_addr[k] = 32'h8; d_addr[k] = 32'h100; d_we[k] = 1'b0;
    i_req[k] = 1'b1; d_req[k] = 1'b1;
    while (got < n && cyc < (n + 2) * (lat + 3) + 10) begin
      tick();
      cyc++;
      if (i_done[k] || d_done[k]) begin
        logic exp_d;
        exp_d = (streak_m != max_of(k));
        streak_m = exp_d ? streak_m + 1 : 0;
        checks++;
        if (d_done[k] !== exp_d || i_done[k] !== !exp_d) begin
          errors++; $display("FAIL streak[%0d] grant %0d: i_done=%b d_done=%b want data=%b",
                             k, got, i_done[k], d_done[k], exp_d);
        end
        checks++;
        if (cyc != (got + 1) * (lat + 3) - 1) begin
          errors++; $display("FAIL streak_time[%0d] grant %0d: cycle %0d want %0d",
                             k, got, cyc, (got + 1) * (lat + 3) - 1);
        end
        got++;
        if (got == n) begin i_req[k] = 1'b0; d_req[k] = 1'b0; end
      end
    end
    checks++;
    if (got != n) begin
      errors++; $display("FAIL streak_timeout[%0d]: got %0d grants want %0d", k, got, n);
    end
    i_req[k] = 1'b0; d_req[k] = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset_in_wait();
    d_we[1] = 1'b0; d_addr[1] = 32'h100; d_req[1] = 1'b1;
    i_addr[1] = 32'h8; i_req[1] = 1'b1;                            // cycle 0: data wins
    tick();                                                        // cycle 1
    checks++;
    if (mem_en[1] !== 1'b1 || owner[1] !== 1'b1) begin
      errors++; $display("FAIL rstwait_c1: en=%b owner=%b want 1 1", mem_en[1], owner[1]);
    end
    tick();                                                        // cycle 2 (WAIT)
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({mem_en[1], mem_we[1], i_done[1], d_done[1], busy[1], owner[1]} !== 6'b0 ||
        mem_addr[1] !== 32'h0 || d_rdata[1] !== 64'h0 || i_rdata[1] !== 64'h0) begin
      errors++; $display("FAIL rstwait_outputs: ctl=%b addr=%h drdata=%h irdata=%h want zeros",
                         {mem_en[1], mem_we[1], i_done[1], d_done[1], busy[1], owner[1]},
                         mem_addr[1], d_rdata[1], i_rdata[1]);
    end
    i_req[1] = 1'b0; d_req[1] = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++;
      if (d_done[1] !== 1'b0 || i_done[1] !== 1'b0 || mem_en[1] !== 1'b0 || busy[1] !== 1'b0) begin
        errors++; $display("FAIL rstwait_quiet c%0d: d_done=%b i_done=%b en=%b busy=%b want 0",
                           c, d_done[1], i_done[1], mem_en[1], busy[1]);
      end
    end
    // The streak was 1 before reset; a cleared streak gives D,D,I instead of D,I.
    test_streak(1, 3);
  endtask

  task automatic test_drop_in_access();
    d_we[0] = 1'b0; d_addr[0] = 32'h80; d_req[0] = 1'b1;           // cycle 0
    tick();                                                        // cycle 1
    checks++;
    if (mem_en[0] !== 1'b1 || mem_addr[0] !== 32'h80) begin
      errors++; $display("FAIL drop_c1: en=%b addr=%h want 1 80", mem_en[0], mem_addr[0]);
    end
    d_req[0] = 1'b0; d_addr[0] = 32'hFFF8; d_we[0] = 1'b1;
    tick();
    tick();                                                        // cycle 3
    checks++;
    if (d_done[0] !== 1'b1 || d_rdata[0] !== mfun(32'h80)) begin
      errors++; $display("FAIL drop_done: d_done=%b d_rdata=%h want 1 %h", d_done[0], d_rdata[0], mfun(32'h80));
    end
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if (mem_en[0] !== 1'b0 || d_done[0] !== 1'b0 || busy[0] !== 1'b0) begin
        errors++; $display("FAIL drop_quiet c%0d: en=%b d_done=%b busy=%b want 0 0 0", c, mem_en[0], d_done[0], busy[0]);
      end
    end
    d_we[0] = 1'b0;
  endtask

  // Transaction-level reference: at most one access in flight, granted in an idle cycle,
  // finishing a fixed number of cycles later.
  task automatic test_random(input int k, input int ncyc);
    logic        act = 1'b0;
    logic        own = 1'b0;
    logic        we_m = 1'b0;
    logic [31:0] a_m = '0;
    logic [63:0] wd_m = '0;
    logic        exp_en;
    int g = 0, dc = 0, freec = 0, streak_m = 0;
    for (int n = 0; n < ncyc; n++) begin
      exp_en = act && (n == g + 1);
      checks++;
      if (mem_en[k] !== exp_en) begin
        errors++; $display("FAIL rnd[%0d] c%0d mem_en: got %b want %b", k, n, mem_en[k], exp_en);
      end
      if (exp_en) begin
        checks++;
        if (mem_addr[k] !== a_m || mem_we[k] !== we_m || (we_m && mem_wdata[k] !== wd_m)) begin
          errors++; $display("FAIL rnd[%0d] c%0d access: addr=%h we=%b wdata=%h want %h %b %h",
                             k, n, mem_addr[k], mem_we[k], mem_wdata[k], a_m, we_m, wd_m);
        end
      end
      checks++;
      if (busy[k] !== (act && n > g)) begin
        errors++; $display("FAIL rnd[%0d] c%0d busy: got %b want %b", k, n, busy[k], act && n > g);
      end
      if (act && n > g) begin
        checks++;
        if (owner[k] !== own) begin
          errors++; $display("FAIL rnd[%0d] c%0d owner: got %b want %b", k, n, owner[k], own);
        end
      end
      if (act && n == dc) begin
        checks++;
        if (i_done[k] !== !own || d_done[k] !== own) begin
          errors++; $display("FAIL rnd[%0d] c%0d done: i=%b d=%b want data=%b", k, n, i_done[k], d_done[k], own);
        end
        if (!we_m) begin
          checks++;
          if ((own ? d_rdata[k] : i_rdata[k]) !== mfun(a_m)) begin
            errors++; $display("FAIL rnd[%0d] c%0d rdata: got %h want %h", k, n,
                               own ? d_rdata[k] : i_rdata[k], mfun(a_m));
          end
        end
        act = 1'b0;
        freec = n + 1;
        if (own) d_req[k] = 1'b0; else i_req[k] = 1'b0;
      end else begin
        checks++;
        if (i_done[k] !== 1'b0 || d_done[k] !== 1'b0) begin
          errors++; $display("FAIL rnd[%0d] c%0d spurious done: i=%b d=%b want 0 0", k, n, i_done[k], d_done[k]);
        end
      end
      if (!i_req[k] && $urandom_range(0, 2) == 0) begin
        i_req[k] = 1'b1;
        i_addr[k] = 32'($urandom_range(0, 63)) << 3;
      end
      if (!d_req[k] && $urandom_range(0, 1) == 0) begin
        d_req[k] = 1'b1;
        d_we[k] = 1'($urandom_range(0, 1));
        d_addr[k] = 32'($urandom_range(0, 63)) << 3;
        d_wdata[k] = {$urandom, $urandom};
      end
      if (!act && n >= freec && (i_req[k] || d_req[k])) begin
        own = d_req[k] && !(i_req[k] && streak_m == max_of(k));
        if (own && i_req[k]) streak_m = (streak_m < max_of(k)) ? streak_m + 1 : streak_m;
        else streak_m = 0;
        we_m = own && d_we[k];
        a_m = own ? d_addr[k] : i_addr[k];
        wd_m = d_wdata[k];
        g = n;
        dc = n + (we_m ? 2 : 2 + lat_of(k));
        act = 1'b1;
      end
      tick();
    end
    i_req[k] = 1'b0; d_req[k] = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      i_req[k] = 1'b0; i_addr[k] = '0;
      d_req[k] = 1'b0; d_we[k] = 1'b0; d_addr[k] = '0; d_wdata[k] = '0;
    end
    test_reset();
    test_load();
    test_store();
    test_fetch_lat3();
    test_streak(0, 10);
    test_reset_in_wait();
    test_drop_in_access();
    test_random(0, 400);
    test_random(1, 400);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
